// File: rtl/mux_arb_pkg.sv
// Shared types for the 4-requester round-robin mux arbiter.
`default_nettype none

package mux_arb_pkg;
  localparam int N_REQ = 4;

  typedef logic [1:0] src_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/mux_4_1.sv
// 4:1 multiplexer for 4-bit data words.
`default_nettype none

module mux_4_1 (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first valid index starting at ptr, wrapping mod 4.
`default_nettype none

module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_valid,
  input  src_t             ptr,
  output logic             any,
  output src_t             winner
);

  src_t idx;

  // Scan from the farthest offset down so the nearest valid index overwrites last.
  always_comb begin
    any    = |in_valid;
    winner = ptr;
    idx    = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + src_t'(k);
      if (in_valid[idx]) winner = idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter with burst lock sharing one registered 4-bit output among four requesters.
`default_nettype none

module rr_mux_arbiter_4
  import mux_arb_pkg::*;
#(
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [3:0]       in_data0,
  input  logic [3:0]       in_data1,
  input  logic [3:0]       in_data2,
  input  logic [3:0]       in_data3,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output src_t             out_src,
  input  logic             out_ready
);

  localparam logic [3:0] BURST_W = 4'(BURST);

  arb_state_t state, state_nxt;
  src_t       ptr, ptr_nxt;
  src_t       owner, owner_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic       can_load;
  logic       accept;
  logic       any;
  src_t       winner;
  src_t       sel;
  logic [3:0] mux_y;

  rr_pick_4 u_pick (
    .in_valid (in_valid),
    .ptr      (ptr),
    .any      (any),
    .winner   (winner)
  );

  mux_4_1 u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (sel),
    .y   (mux_y)
  );

  assign can_load = !out_valid || out_ready;
  assign sel      = (state == LOCK) ? owner : winner;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (can_load && any) begin
          accept    = 1'b1;
          owner_nxt = winner;
          ptr_nxt   = winner + 2'd1;
          beat_nxt  = 4'd1;
          state_nxt = (BURST > 1) ? LOCK : IDLE;
        end
      end
      LOCK: begin
        if (can_load) begin
          if (in_valid[owner]) begin
            accept   = 1'b1;
            beat_nxt = beat_cnt + 4'd1;
            if (beat_cnt + 4'd1 == BURST_W) state_nxt = IDLE;
          end else begin
            // Owner went quiet: release with a bubble rather than re-arbitrating this cycle.
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (accept && !rst) ? (4'b0001 << sel) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      beat_cnt  <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_src   <= 2'd0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= mux_y;
        out_src   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
